// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter, saturating
// Optional leading-zero blanking (digits forced to 4'hF) when BCD_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                  fpga_clk1,
  input  logic                  reset,
  input  logic [IN_W-1:0]       value_in,
  input  logic                  value_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam int SD = (IN_W + 2) / 3;
  localparam int SW = IN_W + 4 * SD;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_next;
  logic [SW-1:0]       scratch;
  logic [CW-1:0]       bit_cnt;
  logic [IN_W-1:0]     pend_val;
  logic                pend;
  logic [4*DIGITS-1:0] bcd_next;
  logic                ovf_next;

  // One correction-plus-shift step; a digit <= 9 plus 3 never leaves its nibble.
  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int d = 0; d < SD; d++) begin
      if (t[IN_W+4*d +: 4] >= 4'd5)
        t[IN_W+4*d +: 4] = t[IN_W+4*d +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  always_ff @(posedge fpga_clk1) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (value_valid || pend) state_next = CONV;
      CONV: if (bit_cnt == CW'(IN_W - 1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
`ifdef BCD_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    busy     = (state != IDLE);
    ovf_next = |scratch[SW-1:IN_W+4*DIGITS];
    bcd_next = scratch[IN_W +: 4*DIGITS];
    if (ovf_next) begin
      bcd_next = {DIGITS{4'h9}};
    end
`ifdef BCD_BLANK_EN
    else begin
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (lead && bcd_next[4*d +: 4] == 4'h0) bcd_next[4*d +: 4] = 4'hF;
        else                                    lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge fpga_clk1) begin
    if (reset) begin
      scratch   <= '0;
      bit_cnt   <= '0;
      pend_val  <= '0;
      pend      <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      bcd_valid <= (state == DONE);
      if (state == DONE) begin
        bcd_out  <= bcd_next;
        overflow <= ovf_next;
      end
      // Strobes arriving while busy (DONE included) park here; the latest one wins.
      if (state == IDLE) begin
        pend <= 1'b0;
      end else if (value_valid) begin
        pend     <= 1'b1;
        pend_val <= value_in;
      end
      case (state)
        IDLE: if (value_valid || pend) begin
          scratch <= {{(4*SD){1'b0}}, (value_valid ? value_in : pend_val)};
          bit_cnt <= '0;
        end
        CONV: begin
          scratch <= dabble(scratch);
          bit_cnt <= bit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq against an arithmetic reference model
module tb_bin2bcd_seq;
  logic        fpga_clk1 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        busy;
  logic        overflow;
  int          checks = 0;
  int          errors = 0;

  bin2bcd_seq #(.IN_W(16), .DIGITS(4)) dut (
    .fpga_clk1  (fpga_clk1),
    .reset      (reset),
    .value_in   (value_in),
    .value_valid(value_valid),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 fpga_clk1 = ~fpga_clk1;

  task automatic tick();
    @(posedge fpga_clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    int c;
    int dig[4];
    bit lead;
    logic [15:0] r;
    c = (v > 9999) ? 9999 : v;
    for (int i = 0; i < 4; i++) begin
      dig[i] = c % 10;
      c = c / 10;
    end
`ifdef BCD_BLANK_EN
    if (v <= 9999) begin
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && dig[i] == 0) dig[i] = 15;
        else lead = 1'b0;
      end
    end
`else
    lead = 1'b0;
`endif
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(dig[i]);
    return r;
  endfunction

  task automatic convert(input int v);
    int n;
    value_in = 16'(v);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    chk("busy_after_load", {31'b0, busy}, 32'd1);
    n = 0;
    while (bcd_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, 32'd17);
    chk("bcd_out", {16'b0, bcd_out}, {16'b0, model_bcd(v)});
    chk("overflow", {31'b0, overflow}, (v > 9999) ? 32'd1 : 32'd0);
    tick();
    chk("valid_one_cycle", {31'b0, bcd_valid}, 32'd0);
    chk("bcd_out_hold", {16'b0, bcd_out}, {16'b0, model_bcd(v)});
  endtask

  initial begin
    int pulses;
    int last_t;
    logic [15:0] seen[$];
    int times[$];
    int v;

    reset = 1'b1;
    tick();
    tick();
    chk("rst_bcd_out", {16'b0, bcd_out}, 32'd0);
    chk("rst_valid", {31'b0, bcd_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    convert(0);
    convert(1234);
    convert(9999);
    convert(7);
    convert(10000);
    convert(65535);
    convert(42);

    // latest pending strobe replaces the earlier one
    value_in = 16'd100; value_valid = 1'b1; tick();
    value_valid = 1'b0; tick(); tick(); tick();
    value_in = 16'd200; value_valid = 1'b1; tick();
    value_valid = 1'b0; tick();
    value_in = 16'd300; value_valid = 1'b1; tick();
    value_valid = 1'b0;
    seen.delete();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bcd_valid === 1'b1) seen.push_back(bcd_out);
    end
    chk("pend_pulses", seen.size(), 32'd2);
    if (seen.size() >= 2) begin
      chk("pend_first", {16'b0, seen[0]}, {16'b0, model_bcd(100)});
      chk("pend_second", {16'b0, seen[1]}, {16'b0, model_bcd(300)});
    end

    // reset abandons a conversion in flight
    value_in = 16'd5678; value_valid = 1'b1; tick();
    value_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1; tick();
    chk("midrst_bcd_out", {16'b0, bcd_out}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_valid", {31'b0, bcd_valid}, 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bcd_valid === 1'b1) pulses++;
    end
    chk("midrst_no_pulse", pulses, 32'd0);
    convert(5678);

    // continuous strobe: one conversion every 18 cycles
    value_in = 16'd4321; value_valid = 1'b1;
    times.delete();
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin
        times.push_back(i);
        chk("cont_bcd_out", {16'b0, bcd_out}, {16'b0, model_bcd(4321)});
        chk("cont_busy_low", {31'b0, busy}, 32'd0);
      end else if (times.size() > 0 && i == times[times.size()-1] + 1) begin
        chk("cont_busy_high", {31'b0, busy}, 32'd1);
      end
    end
    chk("cont_pulse_count", times.size(), 32'd4);
    last_t = -1;
    foreach (times[k]) begin
      if (last_t >= 0) chk("cont_period", times[k] - last_t, 32'd18);
      last_t = times[k];
    end
    value_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(65535, 0)) : int'($urandom_range(9999, 0));
      convert(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble binary-to-BCD converter.
- Sits between the ring-oscillator counting circuit and the seven-segment display controller.
- Takes the counter's binary count and produces a 4-digit packed BCD word for the display, saturating at 9999.
- Uses one correction-plus-shift step per clock, which keeps the block small for the FPGA fabric.

Parameters:
- IN_W, 16: width of the binary input.
- DIGITS, 4: BCD digits presented on bcd_out. Output width is 4*DIGITS.

Ports:
- fpga_clk1  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- value_in  input  IN_W  binary count from the counting circuit.
- value_valid  input  1  one-cycle strobe; value_in is sampled when this is high.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) is in bits [3:0].
- bcd_valid  output  1  one-cycle pulse when bcd_out is updated.
- busy  output  1  high while a conversion is in progress.
- overflow  output  1  high when the last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (synchronous, active-high, takes priority over all else): every output and register clears to 0. This includes bcd_out=0, bcd_valid=0, busy=0, overflow=0, the pending flag and the scratch register. State goes to IDLE.
- Reset mid-conversion: the conversion is abandoned, no bcd_valid pulse, bcd_out=0.
- Scratch register: IN_W binary bits plus SD=(IN_W+2)/3 BCD digits (6 digits for IN_W=16).
- Bit counter: wide enough to count IN_W.
- States: IDLE, CONV, DONE.
- IDLE:
  - If value_valid=1 or pending=1: load the binary field (value_in if value_valid, else the pending value), clear the BCD field, set bit counter=0, clear pending, go to CONV.
  - If value_valid and pending are both set, the live value_valid wins.
- CONV, each cycle:
  - Add 3 to every BCD digit that is >=5.
  - Then shift the whole scratch register left 1 bit; the binary MSB enters digit 0 LSB.
  - Increment the bit counter. After IN_W CONV cycles, go to DONE.
- DONE, one cycle:
  - If any digit at index >=DIGITS is nonzero: overflow=1 and bcd_out = all digits 9 (16'h9999 at default).
  - Else: overflow=0 and bcd_out = the low DIGITS digits.
  - bcd_valid=1 for this cycle only; next state IDLE.
- busy = (state != IDLE).
- Latency: value_valid sampled at edge N gives bcd_valid high after edge N+IN_W+1 (17 cycles at default). The block can accept a new value every IN_W+2 cycles.
- value_valid while busy:
  - The value is captured into a pending register and the pending flag is set.
  - A newer strobe overwrites both the pending value and the flag (latest wins).
  - The conversion in progress is not disturbed.
  - Pending is serviced on the IDLE cycle that follows DONE.
- value_valid in the DONE cycle: treated as "while busy", so it goes to pending.
- bcd_out and overflow hold their values between updates; they never show intermediate scratch contents.
- Width rules:
  - Digits are unsigned 4-bit.
  - The add-3 correction never carries between digits, because its input is <=9 by construction.
  - All-ones input (65535) must not wrap the scratch register.

Optional Feature:
- Macro: BCD_BLANK_EN.
- Defined: in DONE, when not in overflow, leading-zero digits are replaced with 4'hF, which the display controller treats as blank.
  - Scan runs from the most significant digit down.
  - Digit 0 is never blanked, so a zero value gives 16'hFFF0.
  - Overflow output (all 9s) is never blanked.
- Undefined: no blanking. Leading zeros are output as 4'h0. No extra logic is synthesized.

Test Plan:
- Reset, then value_in=0 with value_valid → bcd_valid exactly 17 cycles later, bcd_out=16'h0000, overflow=0. With BCD_BLANK_EN defined, bcd_out=16'hFFF0.
- value_in=1234 → 16'h1234. Then 9999 → 16'h9999, overflow=0. With BCD_BLANK_EN defined, 7 → 16'hFFF7 and 1234 → 16'h1234.
- value_in=10000 → bcd_out=16'h9999, overflow=1. Then value_in=65535 → 16'h9999, overflow=1. Then 42 → 16'h0042, overflow cleared.
- Strobe 100, then strobes 200 and 300 while busy → exactly two bcd_valid pulses, showing 16'h0100 then 16'h0300. The 200 is dropped.
- Strobe 5678, assert reset at cycle 8 of CONV → no bcd_valid, bcd_out=0, busy=0 the cycle after reset. A following strobe of 5678 converts normally to 16'h5678.
- Hold value_valid high continuously with a constant 4321 → bcd_valid every 18 cycles, bcd_out=16'h4321, busy low for exactly one cycle between conversions.
